multiply: RTL and testbench
===========================

MULTIPLY -- requirements
Module: multiply

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (two's complement); legal range WIDTH >= 2.
REQ-002 Parameter PWIDTH, default 2*WIDTH-1, product width; derived, not overridden.
REQ-003 clkin  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a_in  input  WIDTH  signed multiplicand.
REQ-006 b_in  input  WIDTH  signed multiplier.
REQ-007 ready  output  1  result-valid strobe; high for exactly one cycle per completed product.
REQ-008 sign  output  1  sign of the completed product (1 = negative).
REQ-009 product  output  PWIDTH  signed two's-complement product, low PWIDTH bits of a*b.

Function
REQ-010 The block SHALL be free-running with no start input; it SHALL repeatedly sample, compute, and report.
REQ-011 The FSM SHALL have three states: LOAD, CALC, DONE.
REQ-012 In LOAD, the block SHALL capture a_in and b_in at the rising edge and go to CALC.
REQ-013 Capture SHALL store |a_in| and |b_in| as WIDTH-bit unsigned magnitudes; the most negative value -2^(WIDTH-1) SHALL be held as magnitude 2^(WIDTH-1).
REQ-014 Capture SHALL store the result sign as a_in[MSB] XOR b_in[MSB].
REQ-015 CALC SHALL run a shift-add multiply over the magnitudes for exactly WIDTH cycles, one multiplier bit per cycle, into a 2*WIDTH-bit accumulator.
REQ-016 After the WIDTH-th CALC edge, the block SHALL register product (sign applied, truncated to PWIDTH) and sign, enter DONE, and assert ready.
REQ-017 ready SHALL be 1 only in DONE; DONE SHALL return to LOAD on the next edge.
REQ-018 Period: the sample edge is edge 0, ready rises at edge WIDTH, and the next sample is edge WIDTH+2, giving WIDTH+2 cycles per operation (10 for WIDTH=8).
REQ-019 Inputs SHALL be ignored outside LOAD; input changes during CALC or DONE SHALL NOT affect the result in progress.
REQ-020 product and sign SHALL hold their last values until the next DONE entry.
REQ-021 Zero result: product SHALL be 0 and sign SHALL be 0, regardless of operand signs.
REQ-022 Overflow: for (-2^(WIDTH-1))*(-2^(WIDTH-1)), product SHALL be the low PWIDTH bits of +2^(2*WIDTH-2), i.e. 15'h4000 for WIDTH=8; sign SHALL be 0.
REQ-023 The product SHALL equal the result of a signed multiply truncated to PWIDTH bits for all operand pairs.

Reset
REQ-024 While rst_n=0, the block SHALL force state=LOAD, ready=0, product=0, sign=0, and clear internal registers, asynchronously.
REQ-025 Reset mid-CALC SHALL abandon the operation with no ready pulse.
REQ-026 After rst_n rises, the first rising edge SHALL sample the inputs.

Structure
REQ-027 No shared package is needed; the state encoding SHALL be local parameters.
REQ-028 The block SHALL be a single module; any helper for computing magnitudes SHALL be an inline function, not a sub-module.

Verification
REQ-029 a=3, b=-5 -> product=-15 (15'h7FF1), sign=1, ready rises 8 edges after the sample edge.
REQ-030 a=-128, b=-128 -> product=15'h4000, sign=0.
REQ-031 a=0, b=-7 -> product=0, sign=0; a=127, b=127 -> product=16129, sign=0.
REQ-032 20 random signed operand pairs, each applied the edge after ready -> every product matches the truncated signed reference; ready pulses are one cycle wide and 10 cycles apart.
REQ-033 Assert rst_n=0 at the 4th CALC cycle -> ready, product, and sign go 0 immediately; after release, a=-2, b=9 -> product=-18, sign=1.

Source files
------------

// File: rtl/multiply.sv
// Free-running signed sequential multiplier: samples a_in/b_in, runs a WIDTH-cycle
// shift-add over the operand magnitudes, then presents a signed product with a one-cycle ready strobe.
module multiply #(
   parameter int WIDTH  = 8,
   parameter int PWIDTH = 2*WIDTH - 1
) (
   input  logic                     clkin,
   input  logic                     rst_n,
   input  logic signed [WIDTH-1:0]  a_in,
   input  logic signed [WIDTH-1:0]  b_in,
   output logic                     ready,
   output logic                     sign,
   output logic signed [PWIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state, state_nxt;
   logic [2*WIDTH-1:0]     mcand_q;
   logic [2*WIDTH-1:0]     acc_q;
   logic [2*WIDTH-1:0]     acc_nxt;
   logic [WIDTH-1:0]       mplier_q;
   logic [CW-1:0]          cnt_q;
   logic                   neg_q;
   logic                   last_calc;

   // The most negative operand maps to 2^(WIDTH-1), which still fits the unsigned WIDTH-bit result.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [PWIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] mag,
                                                    input logic            neg);
      logic [2*WIDTH-1:0] full;
      full = neg ? (~mag + 1'b1) : mag;
      return full[PWIDTH-1:0];
   endfunction

   assign acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign last_calc = (state == CALC) && (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      case (state)
         LOAD:    state_nxt = CALC;
         CALC:    if (last_calc) state_nxt = DONE;
         DONE: begin
            ready     = 1'b1;
            state_nxt = LOAD;
         end
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         product  <= '0;
         sign     <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               mcand_q  <= {{WIDTH{1'b0}}, magnitude(a_in)};
               mplier_q <= magnitude(b_in);
               neg_q    <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
               acc_q    <= '0;
               cnt_q    <= '0;
            end
            CALC: begin
               acc_q    <= acc_nxt;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CW'(1);
               // A zero result is reported as positive whatever the operand signs were.
               if (last_calc) begin
                  product <= apply_sign(acc_nxt, neg_q);
                  sign    <= neg_q & (acc_nxt != '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multiply.sv
// Directed and random checks for the sequential signed multiplier at WIDTH=8.
module tb_multiply;

   logic               clkin = 1'b0;
   logic               rst_n;
   logic signed [7:0]  a_in;
   logic signed [7:0]  b_in;
   logic               ready;
   logic               sign;
   logic signed [14:0] product;

   int checks = 0;
   int errors = 0;

   multiply #(.WIDTH(8)) dut (
      .clkin   (clkin),
      .rst_n   (rst_n),
      .a_in    (a_in),
      .b_in    (b_in),
      .ready   (ready),
      .sign    (sign),
      .product (product)
   );

   always #5 clkin = ~clkin;

   // Entered on a negedge with the DUT either in LOAD (from_done=0) or in DONE (from_done=1).
   task automatic run_op(input logic signed [7:0] a, input logic signed [7:0] b,
                         input bit from_done, output logic [14:0] p, output logic s,
                         output int lat);
      a_in = a;
      b_in = b;
      if (from_done) begin
         @(posedge clkin);
         @(negedge clkin);
         checks++;
         if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_width got %b want 0", ready);
         end
      end
      @(posedge clkin);
      @(negedge clkin);
      a_in = ~a;
      b_in = b + 8'sd3;
      lat  = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clkin);
         @(negedge clkin);
         if (ready === 1'b1) begin
            lat = k;
            break;
         end
      end
      p = product;
      s = sign;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_in  = 8'sd0;
      b_in  = 8'sd0;
      repeat (2) @(posedge clkin);
      @(negedge clkin);
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
      checks++;
      if (product !== 15'h0000) begin errors++; $display("FAIL reset_product got %h want 0000", product); end
      checks++;
      if (sign !== 1'b0) begin errors++; $display("FAIL reset_sign got %b want 0", sign); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [14:0] p; logic s; int lat;
      run_op(8'sd3, -8'sd5, 1'b0, p, s, lat);
      checks++;
      if (p !== 15'h7FF1) begin errors++; $display("FAIL basic_product got %h want 7ff1", p); end
      checks++;
      if (s !== 1'b1) begin errors++; $display("FAIL basic_sign got %b want 1", s); end
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
   endtask

   task automatic test_boundaries();
      logic [14:0] p; logic s; int lat;
      run_op(-8'sd128, -8'sd128, 1'b1, p, s, lat);
      checks++;
      if (p !== 15'h4000 || s !== 1'b0 || lat !== 8) begin
         errors++;
         $display("FAIL overflow got p=%h s=%b lat=%0d want p=4000 s=0 lat=8", p, s, lat);
      end
      run_op(8'sd0, -8'sd7, 1'b1, p, s, lat);
      checks++;
      if (p !== 15'h0000 || s !== 1'b0 || lat !== 8) begin
         errors++;
         $display("FAIL zero got p=%h s=%b lat=%0d want p=0000 s=0 lat=8", p, s, lat);
      end
      run_op(8'sd127, 8'sd127, 1'b1, p, s, lat);
      checks++;
      if (p !== 15'd16129 || s !== 1'b0 || lat !== 8) begin
         errors++;
         $display("FAIL max_pos got p=%h s=%b lat=%0d want p=3f01 s=0 lat=8", p, s, lat);
      end
      run_op(-8'sd128, 8'sd1, 1'b1, p, s, lat);
      checks++;
      if (p !== 15'h7F80 || s !== 1'b1 || lat !== 8) begin
         errors++;
         $display("FAIL min_times_one got p=%h s=%b lat=%0d want p=7f80 s=1 lat=8", p, s, lat);
      end
   endtask

   task automatic test_random();
      logic [14:0] p; logic s; int lat;
      logic signed [7:0] a, b;
      int full;
      logic [31:0] full_bits;
      for (int i = 0; i < 20; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         full = int'(a) * int'(b);
         full_bits = full;
         run_op(a, b, 1'b1, p, s, lat);
         checks++;
         if (p !== full_bits[14:0]) begin
            errors++;
            $display("FAIL rand_product a=%0d b=%0d got %h want %h", a, b, p, full_bits[14:0]);
         end
         checks++;
         if (s !== (full < 0)) begin
            errors++;
            $display("FAIL rand_sign a=%0d b=%0d got %b want %b", a, b, s, (full < 0));
         end
         checks++;
         if (lat !== 8) begin
            errors++;
            $display("FAIL rand_latency a=%0d b=%0d got %0d want 8", a, b, lat);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [14:0] p; logic s; int lat;
      bit saw_ready;
      run_op(8'sd3, -8'sd5, 1'b1, p, s, lat);
      a_in = 8'sd5;
      b_in = 8'sd7;
      @(posedge clkin);
      @(posedge clkin);
      repeat (3) @(posedge clkin);
      @(negedge clkin);
      rst_n = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0 || product !== 15'h0000 || sign !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got ready=%b p=%h s=%b want 0 0000 0", ready, product, sign);
      end
      saw_ready = 1'b0;
      repeat (3) begin
         @(negedge clkin);
         if (ready !== 1'b0) saw_ready = 1'b1;
      end
      checks++;
      if (saw_ready) begin errors++; $display("FAIL mid_reset_ready got 1 want 0"); end
      rst_n = 1'b1;
      run_op(-8'sd2, 8'sd9, 1'b0, p, s, lat);
      checks++;
      if (p !== 15'h7FEE || s !== 1'b1 || lat !== 8) begin
         errors++;
         $display("FAIL after_reset got p=%h s=%b lat=%0d want p=7fee s=1 lat=8", p, s, lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
